// File: rtl/csi2tx_ecc_hdr_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : csi2tx_ecc_hdr_gen_if
//  Purpose  : Header-beat stream bundle for the CSI-2 TX packet-header ECC
//             generator. It carries the input beat handshake and the output
//             beat handshake.
//  Ports    : hdr_valid/hdr_ready/hdr_data  - input beats, 26 bits per channel
//             out_valid/out_ready/out_hdr   - output beats, 32 bits per channel
//  Modports : master - producer/consumer side (packet builder, lane dist.)
//             slave  - the ECC generator
//  Revision : 1.0 - initial release
// ============================================================================
interface csi2tx_ecc_hdr_gen_if #(
   parameter int NUM_CH = 1
) ();
   logic                   hdr_valid;
   logic                   hdr_ready;
   logic [26*NUM_CH-1:0]   hdr_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [32*NUM_CH-1:0]   out_hdr;

   modport master (
      output hdr_valid, hdr_data, out_ready,
      input  hdr_ready, out_valid, out_hdr
   );

   modport slave (
      input  hdr_valid, hdr_data, out_ready,
      output hdr_ready, out_valid, out_hdr
   );
endinterface
`default_nettype wire

// File: rtl/csi2tx_ecc_hdr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : csi2tx_ecc_hdr_gen
//  Purpose  : CSI-2 TX packet-header ECC generator. It computes the 6-bit
//             Hamming ECC for NUM_CH headers per beat and optionally covers
//             the VCX bits. It assembles 32-bit headers and holds them in a
//             2-entry skid buffer with valid/ready flow control.
//  Ports    : txbyteclkhs      - byte clock
//             txbyteclkhs_rst  - synchronous active-high reset
//             tinit_start      - link init done; low flushes and idles
//             ecc_en           - 0 forces the ECC field to zero
//             err_inj_en/pos   - test-only bit flip on channel 0 data
//             hdr_if           - input and output beat streams (slave)
//             out_hdr_cnt      - running count of emitted headers
//  Revision : 1.0 - initial release
// ============================================================================
module csi2tx_ecc_hdr_gen #(
   parameter int NUM_CH = 1,
   parameter int VCX_EN = 0
) (
   input  wire logic                txbyteclkhs,
   input  wire logic                txbyteclkhs_rst,
   input  wire logic                tinit_start,
   input  wire logic                ecc_en,
   input  wire logic                err_inj_en,
   input  wire logic [4:0]          err_inj_pos,
   csi2tx_ecc_hdr_gen_if.slave      hdr_if,
   output      logic [15:0]         out_hdr_cnt
);

   // Syndrome columns packed as {D25, D24, D23, ..., D0}.
   localparam logic [26*6-1:0] c_COLS = {
      6'h0B, 6'h07, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32,
      6'h31, 6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
      6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};
   localparam int          c_NBITS   = (VCX_EN != 0) ? 26 : 24;
   localparam logic [15:0] c_CNT_INC = 16'(NUM_CH);
   localparam int          c_W       = 32 * NUM_CH;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [c_W-1:0]   r_mem0;        // head entry, drives out_hdr
   logic [c_W-1:0]   r_mem1;
   logic [c_W-1:0]   w_mem0_nxt;
   logic [c_W-1:0]   w_mem1_nxt;
   logic [c_W-1:0]   w_hdr;
   logic [23:0]      w_inj_mask;
   logic [15:0]      r_hdr_cnt;
   logic             w_push;
   logic             w_pop;

   function automatic logic [5:0] f_ecc(input logic [25:0] d);
      logic [5:0] e;
      e = 6'h00;
      for (int i = 0; i < c_NBITS; i++) begin
         if (d[i]) e = e ^ c_COLS[6*i +: 6];
      end
      return e;
   endfunction

   // Positions 24..31 select no flip.
   assign w_inj_mask = (err_inj_en && (err_inj_pos < 5'd24)) ? (24'd1 << err_inj_pos) : 24'd0;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [25:0] w_raw;
      logic [5:0]  w_ecc;
      logic [1:0]  w_vcx;
      logic [23:0] w_flip;

      assign w_raw = hdr_if.hdr_data[26*k +: 26];
      // ECC is taken over the clean data; the injected flip comes after it.
      assign w_ecc = ecc_en ? f_ecc(w_raw) : 6'h00;
      assign w_vcx = (VCX_EN != 0) ? w_raw[25:24] : 2'b00;

      if (k == 0) begin : g_inj
         assign w_flip = w_inj_mask;
      end else begin : g_noinj
         assign w_flip = 24'd0;
      end

      assign w_hdr[32*k +: 32] = {w_vcx, w_ecc, w_raw[23:0] ^ w_flip};
   end

   assign hdr_if.hdr_ready = tinit_start & (r_state != S_FULL);
   assign hdr_if.out_valid = (r_state != S_EMPTY);
   assign hdr_if.out_hdr   = r_mem0;
   assign out_hdr_cnt      = r_hdr_cnt;

   assign w_push = hdr_if.hdr_valid & hdr_if.hdr_ready;
   // A flush cycle discards the head and does not count it as emitted.
   assign w_pop  = hdr_if.out_valid & hdr_if.out_ready & tinit_start;

   always_comb begin
      w_state_nxt = r_state;
      w_mem0_nxt  = r_mem0;
      w_mem1_nxt  = r_mem1;
      if (!tinit_start) begin
         w_state_nxt = S_EMPTY;
         w_mem0_nxt  = '0;
         w_mem1_nxt  = '0;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_push) begin
                  w_mem0_nxt  = w_hdr;
                  w_state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (w_push && w_pop) begin
                  w_mem0_nxt = w_hdr;
               end else if (w_push) begin
                  w_mem1_nxt  = w_hdr;
                  w_state_nxt = S_FULL;
               end else if (w_pop) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_pop) begin
                  w_mem0_nxt  = r_mem1;
                  w_state_nxt = S_ONE;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge txbyteclkhs) begin
      if (txbyteclkhs_rst) begin
         r_state   <= S_EMPTY;
         r_mem0    <= '0;
         r_mem1    <= '0;
         r_hdr_cnt <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_mem0  <= w_mem0_nxt;
         r_mem1  <= w_mem1_nxt;
         if (w_pop) r_hdr_cnt <= r_hdr_cnt + c_CNT_INC;
      end
   end

endmodule
`default_nettype wire

// File: doc/csi2tx_ecc_hdr_gen.md
# csi2tx_ecc_hdr_gen

Parametrised CSI-2 TX packet-header ECC generator with valid/ready flow control. It accepts one or more 24/26-bit packet headers per beat and computes the 6-bit Hamming ECC for each, optionally including the CSI-2 v2 VCX bits. It assembles complete 32-bit packet headers and buffers them in a 2-entry skid buffer. It sits between the low-level-protocol packet builder and the lane distributor. It replaces the fixed single-header, always-flowing ECC flop.

## Interface
- NUM_CH, 1: headers per beat, legal values 1..4.
- VCX_EN, 0: 1 means data bits 25:24 (VCX) are covered by ECC and placed in header bits 31:30. 0 means bits 25:24 are ignored and header bits 31:30 = 0.
- txbyteclkhs  in  1  byte clock; the only clock.
- txbyteclkhs_rst  in  1  synchronous, active-high reset.
- tinit_start  in  1  link-init done; 0 holds the block idle and flushed.
- ecc_en  in  1  sampled with each accepted beat; 0 forces the ECC field to 6'h00.
- err_inj_en  in  1  test-only; flips one data bit of channel 0 after ECC computation.
- err_inj_pos  in  5  bit to flip, 0..23; values 24..31 mean no flip.
- hdr_valid  in  1  input beat valid.
- hdr_ready  out  1  input beat accepted when valid & ready.
- hdr_data  in  26*NUM_CH  channel k occupies [26k+25:26k], laid out as {vcx[1:0], wc[15:0], vc[1:0], dt[5:0]}.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_hdr  out  32*NUM_CH  channel k is {vcx/0[1:0], ecc[5:0], data[23:0]}.
- out_hdr_cnt  out  16  running count of headers emitted, wraps modulo 2^16.

## Operation
- Per-channel parity uses CSI-2 syndrome columns: D0 0x07, D1 0x0B, D2 0x0D, D3 0x0E, D4 0x13, D5 0x15, D6 0x16, D7 0x19, D8 0x1A, D9 0x1C, D10 0x23, D11 0x25, D12 0x26, D13 0x29, D14 0x2A, D15 0x2C, D16 0x31, D17 0x32, D18 0x34, D19 0x38, D20 0x1F, D21 0x2F, D22 0x37, D23 0x3B.
- When VCX_EN=1, the columns also include D24 0x07 and D25 0x0B.
- ECC = XOR of the columns of all set data bits. Bit i of the ECC is parity i.
- Error injection is applied after ECC computation, so the ECC is for the uncorrupted data. It affects channel 0 only and bits 23:0 only.
- Skid buffer: 2 entries, FIFO order. An entry stores the assembled out_hdr for all channels.
- hdr_ready = tinit_start & (count != 2).
- out_valid = (count != 0). out_hdr shows the head entry.
- A push occurs on hdr_valid & hdr_ready. A pop occurs on out_valid & out_ready. When push and pop happen in the same cycle, count is unchanged and order is preserved.
- out_hdr_cnt increments by NUM_CH on each pop.
- Buffer state per count:
  - EMPTY (count 0): push goes to 1; no pop is possible.
  - ONE (count 1): push only goes to 2; pop only goes to 0; push and pop together stays at 1.
  - FULL (count 2): pop goes to 1; push is blocked because ready is low.
- tinit_start = 0: count is cleared to 0 on the next edge, stored entries are discarded, and out_hdr_cnt holds its value. If this occurs mid-transfer, the beat is lost and no partial output is produced.

## Timing
- Reset (synchronous, takes effect at the edge where txbyteclkhs_rst = 1): count = 0, storage = 0, out_hdr_cnt = 0.
  - Resulting outputs: out_valid = 0, out_hdr = 0, hdr_ready = 0 while tinit_start = 0.
- Latency: a beat accepted at edge N appears on out_hdr with out_valid = 1 after edge N, i.e. 1 cycle, when the buffer was empty.
- out_hdr is registered; there is no combinational path from hdr_data to out_hdr.
- hdr_ready depends only on registers and tinit_start; there is no combinational path from out_ready.
- Sustained throughput is 1 beat per cycle while out_ready = 1.
- out_valid and out_hdr stay stable while out_valid & !out_ready.

## Test plan
- NUM_CH=1, VCX_EN=0, ecc_en=1, data 24'h000001 -> out_hdr 32'h07000001 one cycle after acceptance; data 24'h800000 -> ECC 0x3B, out_hdr 32'h3B800000.
- VCX_EN=1, data 24'hFFFFFF with vcx 2'b00 -> ECC 0x3C; with vcx 2'b11 -> ECC 0x30, out_hdr 32'hF0FFFFFF.
- VCX_EN=1, vcx=2'b01, data 24'h000001 -> ECC 0x00 because D24 cancels D0; out_hdr 32'h40000001.
- NUM_CH=4, 6 back-to-back beats with out_ready held 0:
  - two beats are accepted and hdr_ready falls.
  - after out_ready is raised, all beats drain in order and out_hdr_cnt = 24.
- err_inj_en=1, err_inj_pos=5, data 24'h000000 -> out_hdr ch0 32'h00000020 with ECC 0x00; err_inj_pos=30 -> no flip.
- tinit_start dropped with count=2 -> out_valid=0 next cycle, out_hdr_cnt unchanged, no stale beats after tinit_start returns. Synchronous reset mid-stream -> all outputs zero next cycle.
